// File: rtl/bus_pkg.sv
// Shared bus transfer types and widths for the address/data bus.
package bus_pkg;

    localparam int unsigned bus_addr_width_p = 32;
    localparam int unsigned bus_data_width_p = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } trans_t;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } resp_t;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Wait-cycle counter for bus_initiator; o_expire flags the last permitted
// wait cycle so the abort lands exactly i_limit cycles after entry.
module bus_timeout_cnt (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [15:0] i_limit,
    output logic        o_expire
);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_expire = i_enable && (r_cnt == (i_limit - 16'd1));

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: command port -> one NONSEQ transfer -> response port.
// Optional transfer timeout enabled by defining BUS_INITIATOR_TIMEOUT_EN.
module bus_initiator
    import bus_pkg::*;
#(
    parameter int unsigned timeout_p = 255
) (
    input  logic                        main_clk_i,
    input  logic                        main_rst_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_accept_o,
    input  logic                        cmd_write_i,
    input  logic [bus_addr_width_p-1:0] cmd_addr_i,
    input  logic [bus_data_width_p-1:0] cmd_wdata_i,
    output logic [1:0]                  bus_trans_o,
    output logic [bus_addr_width_p-1:0] bus_addr_o,
    output logic                        bus_write_o,
    output logic [bus_data_width_p-1:0] bus_wdata_o,
    input  logic                        bus_ready_i,
    input  logic                        bus_resp_i,
    input  logic [bus_data_width_p-1:0] bus_rdata_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_accept_i,
    output logic [bus_data_width_p-1:0] rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic                        rsp_timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUS  = 2'b01,
        S_RSP  = 2'b10
    } state_t;

    if (timeout_p < 1 || timeout_p > 65535) begin : g_bad_timeout
        $error("bus_initiator: timeout_p out of range 1..65535");
    end

    state_t                      r_state;
    state_t                      w_next_state;
    logic                        w_accept_cmd;
    logic                        w_bus_done;
    logic                        w_timeout;
    logic                        w_expire;

    trans_t                      r_bus_trans;
    logic [bus_addr_width_p-1:0] r_bus_addr;
    logic                        r_bus_write;
    logic [bus_data_width_p-1:0] r_bus_wdata;
    logic [bus_data_width_p-1:0] r_rsp_rdata;
    logic                        r_rsp_err;
    logic                        r_rsp_timeout;

`ifdef BUS_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] TimeoutLimit = 16'(timeout_p);

    logic w_cnt_clear;
    logic w_cnt_enable;

    // Held clear while idle so the count starts at zero on entry to BUS.
    assign w_cnt_clear  = (r_state == S_IDLE);
    assign w_cnt_enable = (r_state == S_BUS) && !bus_ready_i;

    bus_timeout_cnt u_timeout_cnt (
        .i_clk    (main_clk_i),
        .i_rst    (main_rst_i),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_enable),
        .i_limit  (TimeoutLimit),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept_cmd = 1'b0;
        w_bus_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_accept_cmd = 1'b1;
                    w_next_state = S_BUS;
                end
            end
            S_BUS: begin
                // Ready takes priority over a timeout expiring in the same cycle.
                if (bus_ready_i) begin
                    w_bus_done   = 1'b1;
                    w_next_state = S_RSP;
                end else if (w_expire) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_accept_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            r_bus_trans   <= IDLE;
            r_bus_addr    <= '0;
            r_bus_write   <= 1'b0;
            r_bus_wdata   <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept_cmd) begin
                r_bus_trans <= NONSEQ;
                r_bus_addr  <= cmd_addr_i;
                r_bus_write <= cmd_write_i;
                r_bus_wdata <= cmd_wdata_i;
            end
            if (w_bus_done || w_timeout) begin
                r_bus_trans   <= IDLE;
                r_bus_addr    <= '0;
                r_bus_write   <= 1'b0;
                r_bus_wdata   <= '0;
                r_rsp_rdata   <= (w_bus_done && !r_bus_write) ? bus_rdata_i : '0;
                r_rsp_err     <= w_bus_done ? (bus_resp_i == ERROR) : 1'b1;
                r_rsp_timeout <= w_timeout;
            end
        end
    end

    assign cmd_accept_o  = (r_state == S_IDLE);
    assign rsp_valid_o   = (r_state == S_RSP);
    assign bus_trans_o   = r_bus_trans;
    assign bus_addr_o    = r_bus_addr;
    assign bus_write_o   = r_bus_write;
    assign bus_wdata_o   = r_bus_wdata;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Bus initiator that drives the 2-bit-transaction/32-bit address/data bus at its requester end. It accepts single read/write commands over a valid/accept command port and runs each one as a single bus transfer. It returns the read data and error status over a valid/accept response port. Only one transfer is outstanding at a time. It sits between a local controller (sequencer, debug port) and any block exposing the `bus_*` responder interface.

## Interface
- `timeout_p`, default 255: cycles waited for `bus_ready_i` before a transfer is aborted. Range 1..65535. Only used with `BUS_INITIATOR_TIMEOUT_EN`.
- `main_clk_i` input 1: clock; all logic on the rising edge.
- `main_rst_i` input 1: reset, synchronous, active-high.
- `cmd_valid_i` input 1: command request.
- `cmd_accept_o` output 1: command accepted when high together with `cmd_valid_i`.
- `cmd_write_i` input 1: 1 = write, 0 = read.
- `cmd_addr_i` input 32: byte address.
- `cmd_wdata_i` input 32: write data.
- `bus_trans_o` output 2: transfer type, IDLE=2'b00, NONSEQ=2'b10. BUSY and SEQ are never driven.
- `bus_addr_o` output 32: transfer address.
- `bus_write_o` output 1: transfer direction.
- `bus_wdata_o` output 32: write data.
- `bus_ready_i` input 1: responder completion strobe.
- `bus_resp_i` input 1: responder error, valid with `bus_ready_i`.
- `bus_rdata_i` input 32: read data, valid with `bus_ready_i`.
- `rsp_valid_o` output 1: response available.
- `rsp_accept_i` input 1: response consumed.
- `rsp_rdata_o` output 32: captured read data.
- `rsp_err_o` output 1: bus error or timeout.
- `rsp_timeout_o` output 1: transfer aborted by timeout.

## Operation
- FSM states: IDLE, BUS, RSP. Reset state is IDLE.
- `cmd_accept_o` = (state == IDLE). It is combinational from the state register only.
- IDLE: on `cmd_valid_i` go to BUS. Register addr, write and wdata onto the `bus_*` outputs and set `bus_trans_o` to NONSEQ.
- BUS: `bus_*` outputs stay stable until completion. On `bus_ready_i`:
  - capture `bus_rdata_i`; writes capture 0.
  - capture `rsp_err_o` = `bus_resp_i`.
  - set `bus_trans_o` to IDLE, `bus_addr_o`, `bus_wdata_o` and `bus_write_o` to 0, then go to RSP.
- RSP: `rsp_valid_o` = 1 and the response outputs stay stable. On `rsp_accept_i` clear `rsp_valid_o` and go to IDLE.
- `bus_ready_i` is ignored outside BUS. A late or spurious ready has no effect.
- Reset values of all outputs are 0, including `bus_trans_o` = IDLE. `cmd_accept_o` is 1 after reset.
- Reset mid-transfer: all outputs return to reset values on the next edge. The response is discarded, and the responder sees IDLE.

## Timing
- Command accepted at edge N → NONSEQ visible after edge N.
- `bus_ready_i` sampled high at edge M → `rsp_valid_o` = 1 and `bus_trans_o` = IDLE after edge M.
- A zero-wait responder (ready in the first NONSEQ cycle) gives 2 cycles from command to response.
- Response accepted at edge K → `cmd_accept_o` = 1 after K. Minimum command-to-command spacing is 3 cycles.
- Ready and timeout expiry in the same cycle: ready wins and `rsp_timeout_o` = 0.

## Configuration
- `BUS_INITIATOR_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle without ready.
  - When the counter reaches `timeout_p`, go to RSP with `rsp_err_o` = 1, `rsp_timeout_o` = 1 and `rsp_rdata_o` = 0. `bus_trans_o` drops to IDLE.
- Undefined: no counter, BUS waits indefinitely, and `rsp_timeout_o` is tied to 0. The port list is identical in both builds.

## Structure
- Package `bus_pkg`:
  - `trans_t` enum (IDLE, BUSY, NONSEQ, SEQ).
  - `resp_t` (OKAY=0, ERROR=1).
  - `bus_addr_width_p` = 32 and `bus_data_width_p` = 32.
- FSM state type stays local to `bus_initiator`.
- One sub-module: `bus_timeout_cnt` (clear, enable, limit input, expire output). It is instantiated only under `BUS_INITIATOR_TIMEOUT_EN`.

## Test plan
- Read 0x0000_0010 with ready in the first NONSEQ cycle and rdata 0xCAFE_F00D:
  - `bus_trans_o` = NONSEQ for exactly 1 cycle.
  - `rsp_valid_o` 2 cycles after accept, `rsp_rdata_o` = 0xCAFE_F00D, `rsp_err_o` = 0.
- Write 0x0000_0020 / 0x1234_5678 with ready after 3 wait cycles:
  - addr, write and wdata stable for 4 NONSEQ cycles.
  - response has `rsp_rdata_o` = 0 and `rsp_err_o` = 0.
- Read with `bus_resp_i` = 1 at ready → `rsp_err_o` = 1, `rsp_timeout_o` = 0.
- With `rsp_accept_i` held low for 5 cycles: response stable; `cmd_accept_o` = 0 throughout; `cmd_valid_i` is not accepted.
- `BUS_INITIATOR_TIMEOUT_EN` with `timeout_p` = 4 and ready never asserted:
  - abort after 4 BUS cycles with `rsp_err_o` = 1 and `rsp_timeout_o` = 1.
  - a later spurious ready is ignored.
- Assert `main_rst_i` during BUS → `bus_trans_o` = IDLE, `rsp_valid_o` = 0 and `cmd_accept_o` = 1 after the next edge.
